// File: rtl/gf_op_sequencer.sv
// gf_op_sequencer: sequential front-end for the shared GF(2^m) datapath.
// It accepts one command at a time and runs the command as one or more passes
// over a single carry-less multiplier and a single polynomial reducer.
// Integer ADD and MUL are also available, and each takes one pass.
//
// Optional feature macro: GF_OP_SEQUENCER_GF_EXP_EN
//   - Defined:   GF_EXP (op 4) is built. It uses square-and-multiply, scanning the exponent from MSB to LSB.
//   - Undefined: op 4 is rejected in the same way as any other illegal op.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_ready is high only in IDLE
//   cmd_op            0=ADD 1=MUL 2=CLMUL 3=GF_MUL 4=GF_EXP, 5..7 illegal
//   cmd_grade         field grade m (GF ops only, legal range 2..MAX_GF)
//   cmd_a, cmd_b      operands (for GF_EXP: base and exponent)
//   rsp_valid/ready   response handshake
//   rsp_data          result, zero-extended to 2*DATA_WIDTH
//   rsp_err           illegal op or grade
//   busy              high whenever the sequencer is not IDLE
//
// Handshake rule (both channels): a transfer happens on a rising edge where
// valid && ready. The producer holds its payload stable while valid is high
// and ready is low. The producer does not withdraw valid before the transfer.
module gf_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_GF     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_op,
  input  logic [$clog2(DATA_WIDTH):0] cmd_grade,
  input  logic [DATA_WIDTH-1:0]       cmd_a,
  input  logic [DATA_WIDTH-1:0]       cmd_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [2*DATA_WIDTH-1:0]     rsp_data,
  output logic                        rsp_err,
  output logic                        busy
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_EXEC   = 4'd1;
  localparam logic [3:0] S_CLMUL  = 4'd2;
  localparam logic [3:0] S_REDUCE = 4'd3;
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
  localparam logic [3:0] S_SQ_MUL = 4'd4;
  localparam logic [3:0] S_SQ_RED = 4'd5;
  localparam logic [3:0] S_ML_MUL = 4'd6;
  localparam logic [3:0] S_ML_RED = 4'd7;
  localparam int         IW       = (MAX_GF > 2) ? $clog2(MAX_GF) : 1;
`endif
  localparam logic [3:0] S_DONE   = 4'd8;

  // Irreducible polynomial for each legal grade. Bit m of each value is the leading term.
  function automatic logic [16:0] poly_rom(input logic [GW-1:0] m);
    case (int'(m))
      2:  return 17'd7;
      3:  return 17'd11;
      4:  return 17'd19;
      5:  return 17'd37;
      6:  return 17'd67;
      7:  return 17'd137;
      8:  return 17'd285;
      9:  return 17'd529;
      10: return 17'd1033;
      11: return 17'd2053;
      12: return 17'd4179;
      13: return 17'd8219;
      14: return 17'd17475;
      15: return 17'd32771;
      16: return 17'd69643;
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] grade_mask(input logic [GW-1:0] m);
    return (DATA_WIDTH'(1) << m) - DATA_WIDTH'(1);
  endfunction

  function automatic logic [PW-1:0] clmul(input logic [DATA_WIDTH-1:0] x,
                                          input logic [DATA_WIDTH-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (y[i]) r = r ^ (PW'(x) << i);
    return r;
  endfunction

  // Reduce a product of two m-bit field elements. The product has at most
  // 2m-1 bits. Each set bit at position m or above is cleared by XORing in
  // the polynomial shifted to that position. The highest bit is handled first.
  function automatic logic [DATA_WIDTH-1:0] reduce(input logic [PW-1:0] p,
                                                   input logic [GW-1:0] m);
    logic [PW-1:0] r;
    logic [16:0]   poly;
    r    = p;
    poly = poly_rom(m);
    for (int j = 2 * MAX_GF - 2; j >= 2; j--)
      if (j >= int'(m) && r[j]) r = r ^ (PW'(poly) << (j - int'(m)));
    return r[DATA_WIDTH-1:0] & grade_mask(m);
  endfunction

  logic [3:0]            state;
  logic [2:0]            op_r;
  logic [GW-1:0]         grade_r;
  logic [DATA_WIDTH-1:0] a_r, b_r;
  logic [PW-1:0]         prod_r;
  logic                  err_r;
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
  logic [DATA_WIDTH-1:0] acc_r;
  logic [IW-1:0]         idx_r;
`endif

  // These signals decide only the next state and which operands to latch.
  // The datapath itself sees registered values only.
  logic grade_ok, cmd_gf, cmd_legal;
  assign grade_ok = (cmd_grade >= GW'(2)) && (cmd_grade <= GW'(MAX_GF));
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
  assign cmd_gf = (cmd_op == 3'd3) || (cmd_op == 3'd4);
`else
  assign cmd_gf = (cmd_op == 3'd3);
`endif
  assign cmd_legal = (cmd_op <= 3'd2) || (cmd_gf && grade_ok);

  // Shared datapath: one adder, one integer multiplier, one carry-less
  // multiplier and one reducer. The current state selects the operands.
  logic [DATA_WIDTH:0]   sum_out;
  logic [PW-1:0]         mult_out, clmul_out, exec_result;
  logic [DATA_WIDTH-1:0] mul_x, mul_y, red_out;

  assign sum_out  = {1'b0, a_r} + {1'b0, b_r};
  assign mult_out = PW'(a_r) * PW'(b_r);

  always_comb begin
    mul_x = a_r;
    mul_y = b_r;
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
    case (state)
      S_SQ_MUL: begin mul_x = acc_r; mul_y = acc_r; end
      S_ML_MUL: begin mul_x = acc_r; mul_y = a_r;   end
      default:  ;
    endcase
`endif
  end

  assign clmul_out = clmul(mul_x, mul_y);
  assign red_out   = reduce(prod_r, grade_r);

  always_comb begin
    exec_result = '0;
    if (!err_r) begin
      case (op_r)
        3'd0:    exec_result = PW'(sum_out);
        3'd1:    exec_result = mult_out;
        3'd2:    exec_result = clmul_out;
        default: exec_result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= '0;
      grade_r  <= '0;
      a_r      <= '0;
      b_r      <= '0;
      prod_r   <= '0;
      err_r    <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
      acc_r    <= '0;
      idx_r    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r    <= cmd_op;
            grade_r <= cmd_grade;
            a_r     <= cmd_gf ? (cmd_a & grade_mask(cmd_grade)) : cmd_a;
            b_r     <= cmd_gf ? (cmd_b & grade_mask(cmd_grade)) : cmd_b;
            err_r   <= !cmd_legal;
            // An illegal command takes the one-pass route, so its error response appears at the same latency.
            if (!cmd_legal || cmd_op <= 3'd2) state <= S_EXEC;
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
            else if (cmd_op == 3'd4) begin
              acc_r <= DATA_WIDTH'(1);
              idx_r <= IW'(cmd_grade - GW'(1));
              state <= S_SQ_MUL;
            end
`endif
            else state <= S_CLMUL;
          end
        end
        S_EXEC: begin
          rsp_data <= exec_result;
          rsp_err  <= err_r;
          state    <= S_DONE;
        end
        S_CLMUL: begin
          prod_r <= clmul_out;
          state  <= S_REDUCE;
        end
        S_REDUCE: begin
          rsp_data <= PW'(red_out);
          rsp_err  <= 1'b0;
          state    <= S_DONE;
        end
`ifdef GF_OP_SEQUENCER_GF_EXP_EN
        S_SQ_MUL, S_ML_MUL: begin
          prod_r <= clmul_out;
          state  <= (state == S_SQ_MUL) ? S_SQ_RED : S_ML_RED;
        end
        S_SQ_RED, S_ML_RED: begin
          acc_r <= red_out;
          // After squaring, multiply by the base if the current exponent bit is set.
          // Otherwise move to the next bit, or finish once bit 0 is done.
          if (state == S_SQ_RED && b_r[idx_r]) begin
            state <= S_ML_MUL;
          end else if (idx_r == '0) begin
            rsp_data <= PW'(red_out);
            rsp_err  <= 1'b0;
            state    <= S_DONE;
          end else begin
            idx_r <= idx_r - IW'(1);
            state <= S_SQ_MUL;
          end
        end
`endif
        S_DONE: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);

endmodule

// File: tb/tb_gf_op_sequencer.sv
// tb_gf_op_sequencer: self-checking bench for gf_op_sequencer.
// Uses directed cases and random commands. The reference model computes GF
// products by Horner-style shift-and-reduce and computes exponents by
// right-to-left square-and-multiply.
module tb_gf_op_sequencer;
  localparam int DW = 32;
  localparam int GW = $clog2(DW) + 1;

`ifdef GF_OP_SEQUENCER_GF_EXP_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [GW-1:0] cmd_grade = '0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [2*DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gf_op_sequencer #(.DATA_WIDTH(DW), .MAX_GF(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_grade(cmd_grade), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  // ---------------- reference model ----------------
  int unsigned poly_tab [0:16] = '{0, 0, 7, 11, 19, 37, 67, 137, 285, 529, 1033,
                                   2053, 4179, 8219, 17475, 32771, 69643};

  function automatic longint unsigned clmul_ref(longint unsigned a, longint unsigned b);
    longint unsigned r = 0;
    for (int i = 0; i < DW; i++) if (b[i]) r ^= (a << i);
    return r;
  endfunction

  // Horner-style evaluation: shift, reduce by the polynomial when bit m is set, then add a.
  function automatic longint unsigned gf_mul_ref(longint unsigned a, longint unsigned b, int m);
    longint unsigned r = 0;
    for (int i = m - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[m]) r ^= longint'(poly_tab[m]);
      if (b[i]) r ^= a;
    end
    return r;
  endfunction

  function automatic longint unsigned gf_exp_ref(longint unsigned a, longint unsigned e, int m);
    longint unsigned r = 1, base = a;
    for (int i = 0; i < m; i++) begin
      if (e[i]) r = gf_mul_ref(r, base, m);
      base = gf_mul_ref(base, base, m);
    end
    return r;
  endfunction

  task automatic model(input int op, input int m, input longint unsigned a, input longint unsigned b,
                       output longint unsigned data, output bit err, output int lat);
    bit gf_ok = (m >= 2) && (m <= 16);
    longint unsigned mask = gf_ok ? ((64'd1 << m) - 1) : 64'd0;
    data = 0; err = 0; lat = 1;
    case (op)
      0: data = a + b;
      1: data = a * b;
      2: data = clmul_ref(a, b);
      3: if (gf_ok) begin data = gf_mul_ref(a & mask, b & mask, m); lat = 2; end
         else err = 1;
      4: if (EXP_EN && gf_ok) begin
           data = gf_exp_ref(a & mask, b & mask, m);
           lat  = 2 * m + 2 * $countones(b & mask);
         end else err = 1;
      default: err = 1;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          hung = 0;
  int          bp_mode = 0;  // 0: always ready, 1: random ready, 2: held low

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: compare each response when rsp_valid rises, then check that it holds stable until the handshake.
  bit              prev_valid = 0, hs_pending = 0;
  longint unsigned held_data;
  bit              held_err;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      hs_pending = 0;
    end else begin
      if (hs_pending) begin
        check("ready_after_ack", cmd_ready, 1);
        hs_pending = 0;
      end
      if (rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got data %h err %0b with nothing expected", rsp_data, rsp_err);
        end else begin
          logic [64:0] e;
          int l, k;
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          k = acc_q.pop_front();
          check("rsp_data", rsp_data, e[63:0]);
          check("rsp_err", rsp_err, e[64]);
          check("latency", cyc - k, l);
        end
        held_data = rsp_data;
        held_err  = rsp_err;
      end else if (rsp_valid) begin
        check("hold_data", rsp_data, held_data);
        check("hold_err", rsp_err, held_err);
        check("ready_in_done", cmd_ready, 0);
      end
      if (rsp_valid && rsp_ready) hs_pending = 1;
      prev_valid = rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(output bit ok);
    ok = 0;
    if (hung) return;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin ok = 1; return; end
      @(posedge clk); #1;
    end
    hung = 1;
    checks++; errors++;
    $display("FAIL idle_timeout: cmd_ready still %0b after 400 cycles, required 1", cmd_ready);
  endtask

  task automatic send(input int op, input int m, input longint unsigned a, input longint unsigned b,
                      input bit track);
    bit ok;
    longint unsigned d;
    bit e;
    int l;
    wait_idle(ok);
    if (!ok) return;
    cmd_op    = op[2:0];
    cmd_grade = m[GW-1:0];
    cmd_a     = a[DW-1:0];
    cmd_b     = b[DW-1:0];
    cmd_valid = 1'b1;
    if (track) begin
      model(op, m, a, b, d, e, l);
      exp_q.push_back({e, d});
      lat_q.push_back(l);
    end
    @(posedge clk); #1;
    if (track) acc_q.push_back(cyc);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_a     = $urandom;
    cmd_b     = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    send(0, 0, 64'hFFFF_FFFF, 1, 1);
    send(3, 4, 7, 9, 1);
    send(3, 8, 2, 64'h80, 1);
    send(4, 4, 2, 64'hF, 1);
    send(4, 4, 2, 0, 1);
    send(3, 1, 3, 3, 1);
    send(6, 4, 5, 5, 1);
    send(1, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1);
    send(2, 0, 64'h8000_0001, 64'h8000_0003, 1);
    send(3, 17, 3, 3, 1);

    // Response backpressure: rsp_ready is held low for 5 cycles after rsp_valid rises
    wait_idle(ok);
    bp_mode = 2;
    send(3, 4, 7, 9, 1);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin @(posedge clk); #1; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL bp_valid_timeout: rsp_valid %0b, required 1", rsp_valid);
    end
    repeat (5) @(posedge clk);
    #1;
    bp_mode = 0;

    // Apply reset while an operation is still running
    wait_idle(ok);
    if (EXP_EN) send(4, 4, 2, 64'hF, 0);
    else        send(3, 4, 7, 9, 0);
    if (!hung) begin
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midop_reset");
      @(posedge clk); #1;
      rst = 1'b0;
    end
    send(0, 0, 2, 3, 1);

    // Random commands with random response backpressure
    bp_mode = 1;
    for (int n = 0; n < 150; n++) begin
      int sel, op, m;
      sel = $urandom_range(0, 9);
      m   = $urandom_range(2, 16);
      case (sel)
        0, 1: op = 0;
        2:    op = 1;
        3:    op = 2;
        4, 5: op = 3;
        6, 7: op = 4;
        8:    op = $urandom_range(5, 7);
        default: begin
          op = $urandom_range(3, 4);
          case ($urandom_range(0, 3))
            0: m = 0;
            1: m = 1;
            2: m = 17;
            default: m = 31;
          endcase
        end
      endcase
      send(op, m, longint'($urandom), longint'($urandom), 1);
    end
    bp_mode = 0;

    wait_idle(ok);
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gf_op_sequencer.md
Name: gf_op_sequencer

Overview:
Sequential front-end that owns one shared cl_modules datapath and one cl_rca_mult, and runs multi-step operations on them under a valid/ready command/response handshake.
- Integer ADD/MUL and raw carry-less MUL take one pass.
- GF(2^m) multiply takes two passes: carry-less product, then polynomial reduction.
- GF(2^m) exponentiation uses left-to-right square-and-multiply.
- Sits between a host/command FIFO and the combinational GF datapath.

Parameters:
- DATA_WIDTH, 32, operand width of a/b and of the datapath instances.
- MAX_GF, 16, largest legal field grade m. Must be ≤16 and ≤DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0=ADD, 1=MUL, 2=CLMUL, 3=GF_MUL, 4=GF_EXP, 5..7 illegal.
- cmd_grade  in  $clog2(DATA_WIDTH)+1  field grade m; used by GF ops only.
- cmd_a  in  DATA_WIDTH  operand a / GF base.
- cmd_b  in  DATA_WIDTH  operand b / GF exponent.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  2*DATA_WIDTH  result, zero-extended.
- rsp_err  out  1  illegal op or grade.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. Reset asserted mid-operation aborts it; no response is produced.
- Command accept: cmd_valid&&cmd_ready at edge k latches op, grade, a, b. cmd_ready=1 only in IDLE.
- Irreducible polynomial ROM, indexed by m:
  - m=2..16 → 7, 11, 19, 37, 67, 137, 285, 529, 1033, 2053, 4179, 8219, 17475, 32771, 69643.
  - Drives polyn_red_in; polyn_grade=m.
- GF masking: a and b are masked to m bits for GF_MUL. For GF_EXP, a is masked to m bits and e=b[m-1:0].
- States: IDLE, EXEC, CLMUL, REDUCE, SQ_MUL, SQ_RED, ML_MUL, ML_RED, DONE.
- ADD/MUL/CLMUL (IDLE→EXEC→DONE):
  - Datapath result is captured at edge k+1; rsp_valid is high after k+1.
  - ADD: rsp_data = {carry, sum}.
  - MUL: rsp_data = a*b.
  - CLMUL: rsp_data = carry-less a·b.
- GF_MUL (IDLE→CLMUL→REDUCE→DONE):
  - Carry-less product captured at k+1.
  - The captured product feeds reduc_in; the reduced result is captured at k+2.
  - rsp_data[DATA_WIDTH-1:m]=0.
- GF_EXP:
  - acc=1, bit index i=m-1.
  - Per bit: SQ_MUL→SQ_RED computes acc=acc² mod p. If e[i]=1, ML_MUL→ML_RED computes acc=acc·a mod p.
  - Then i decrements; after i=0 go to DONE.
  - Latency 2m+2·popcount(e) edges. e=0 → result 1.
- Illegal op, or GF op with m<2 or m>MAX_GF: IDLE→DONE at k+1 with rsp_err=1, rsp_data=0.
- DONE: rsp_valid=1. rsp_data/rsp_err are held stable until rsp_valid&&rsp_ready. Then go to IDLE; cmd_ready=1 on the following cycle.
- Datapath control fields (sum_funct, exp_funct, red_funct, carry_option) are registered per state; no combinational path from cmd_* to the datapath.

Optional Feature:
- GF_OP_SEQUENCER_GF_EXP_EN:
  - Defined: GF_EXP is supported as above.
  - Undefined: SQ_*/ML_* states and the exponent counter are not built; op 4 is treated as illegal (rsp_err=1, latency 1).

Test Plan:
- ADD a=0xFFFFFFFF, b=1 → rsp_data=0x1_0000_0000, rsp_err=0, rsp_valid one edge after accept.
- GF_MUL m=4, a=0x7, b=0x9 → intermediate CLMUL 0x3F, rsp_data=0xA, latency 2. Also m=8, a=0x02, b=0x80 → 0x1D.
- GF_EXP m=4, a=0x2, e=0xF → rsp_data=0x1, latency 16. e=0 → 0x1, latency 8.
- GF_MUL m=1, a=3, b=3 → rsp_err=1, rsp_data=0, latency 1. op=6 → rsp_err=1.
- Result backpressure: GF_MUL done with rsp_ready low 5 cycles → rsp_data constant, cmd_ready=0 throughout, IDLE one edge after handshake.
- rst pulsed during GF_EXP SQ_RED → all outputs return to reset values immediately. Next ADD 2+3 → 5.
